// File: rtl/rr_arbiter_pkg.sv
// Shared constants for the round-robin arbiter.
// State encoding and width helpers.
package rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_prioritydecoder.sv
// Priority decoder: index of the highest-order set bit.
// valid flags that any bit is set.
module prioritydecoder
    import rr_arbiter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) idx = IW'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered grant and hold watchdog.
// Priority rotates downward past the last winner.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDXW     = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HW = cnt_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = {HW{1'b1}};
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam bit WD_EN = (MAX_HOLD != 0);

    logic [0:0]      state;
    logic [IDXW-1:0] last_idx;
    logic [HW-1:0]   hold_cnt;

    logic [N-1:0]    lowmask;
    logic [N-1:0]    masked;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] winner;
    logic            any;

    logic            rel_done;
    logic            rel_drop;
    logic            rel_wd;
    logic            rel;

    // Only requesters strictly below the last winner get first pick.
    assign lowmask = ~({N{1'b1}} << last_idx);
    assign masked  = req & lowmask;
    assign cand    = (|masked) ? masked : req;

    prioritydecoder #(.WIDTH(N)) u_pd (
        .req   (cand),
        .idx   (winner),
        .valid (any)
    );

    assign rel_done = done[gnt_idx];
    assign rel_drop = ~req[gnt_idx];
    assign rel_wd   = WD_EN && (hold_cnt == HOLD_LIM);
    assign rel      = rel_done | rel_drop | rel_wd;

    assign gnt_valid = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            timeout  <= 1'b0;
            last_idx <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (any) begin
                        gnt      <= N'(1) << winner;
                        gnt_idx  <= winner;
                        last_idx <= winner;
                        hold_cnt <= HW'(1);
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        gnt     <= '0;
                        state   <= ST_IDLE;
                        timeout <= rel_wd & ~rel_done & ~rel_drop;
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt     <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=4) with watchdog 4 and
// a second instance with the watchdog disabled.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       gv_a, gv_b;
    logic       to_a, to_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a), .gnt_idx(idx_a),
        .gnt_valid(gv_a), .timeout(to_a)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(0)) dut_nowd (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_b), .gnt_idx(idx_b),
        .gnt_valid(gv_b), .timeout(to_b)
    );

    typedef struct {
        bit busy;
        int last;
        int idx;
        int hold;
        bit to;
    } mst_t;

    typedef struct {
        logic [3:0] gnt;
        int         idx;
        bit         v;
        bit         to;
    } eo_t;

    typedef struct {
        eo_t a;
        eo_t b;
    } exp_t;

    exp_t sbq[$];
    int   order[$];
    int   to_cnt_a = 0;
    int   to_cnt_b = 0;
    bit   pv = 1'b0;
    mst_t m0, m1;

    function automatic void chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, expv, $time);
        end
    endfunction

    // Search downward from just below the last winner, wrapping at 0.
    function automatic int pick(logic [3:0] r, int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last - k + 8) % 4;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic void step(input mst_t s, input logic [3:0] r,
                                 input logic [3:0] d, input bit rs,
                                 input int mh, output mst_t n,
                                 output eo_t e);
        n = s;
        if (rs) begin
            n.busy = 0; n.last = 0; n.idx = 0; n.hold = 0; n.to = 0;
        end else if (!s.busy) begin
            n.to = 0;
            if (r != 4'd0) begin
                n.idx  = pick(r, s.last);
                n.last = n.idx;
                n.busy = 1;
                n.hold = 1;
            end
        end else begin
            bit rd, rr, rw;
            rd = d[s.idx];
            rr = !r[s.idx];
            rw = (mh != 0) && (s.hold >= mh);
            if (rd || rr || rw) begin
                n.busy = 0;
                n.to   = rw && !rd && !rr;
            end else begin
                n.to   = 0;
                n.hold = s.hold + 1;
            end
        end
        e.gnt = n.busy ? (4'd1 << n.idx) : 4'd0;
        e.idx = n.idx;
        e.v   = n.busy;
        e.to  = n.to;
    endfunction

    task automatic cyc(input logic [3:0] r, input logic [3:0] d,
                       input bit rs);
        mst_t n0, n1;
        exp_t x;
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        step(m0, r, d, rs, 4, n0, x.a);
        step(m1, r, d, rs, 0, n1, x.b);
        m0 = n0;
        m1 = n1;
        sbq.push_back(x);
        #1;
    endtask

    function automatic logic [3:0] dn2();
        if (m0.busy && m0.hold == 2) return 4'd1 << m0.idx;
        return 4'd0;
    endfunction

    task automatic check_order(string name, input int e[$]);
        chk({name, "_cnt"}, order.size(), e.size());
        for (int i = 0; i < e.size() && i < order.size(); i++)
            chk($sformatf("%s_%0d", name, i), order[i], e[i]);
    endtask

    task automatic restart();
        cyc(4'd0, 4'd0, 1'b1);
        cyc(4'd0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        order.delete();
        to_cnt_a = 0;
        to_cnt_b = 0;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("gnt_a", gnt_a, e.a.gnt);
            chk("idx_a", idx_a, e.a.idx);
            chk("valid_a", gv_a, e.a.v);
            chk("timeout_a", to_a, e.a.to);
            chk("gnt_b", gnt_b, e.b.gnt);
            chk("valid_b", gv_b, e.b.v);
            chk("timeout_b", to_b, e.b.to);
            chk("onehot_a", $onehot0(gnt_a), 1);
            chk("vor_a", gv_a, |gnt_a);
            if (gv_a && !pv) order.push_back(int'(idx_a));
            pv = gv_a;
            if (to_a) to_cnt_a++;
            if (to_b) to_cnt_b++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stalled");
    end

    initial begin
        m0 = '{0, 0, 0, 0, 0};
        m1 = '{0, 0, 0, 0, 0};
        req  = 4'd0;
        done = 4'd0;
        rst  = 1'b1;
        cyc(4'd0, 4'd0, 1'b1);
        cyc(4'd0, 4'd0, 1'b1);
        chk("rst_gnt", gnt_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_valid", gv_a, 0);
        chk("rst_to", to_a, 0);
        restart();

        // full request vector, done two cycles into each grant
        for (int k = 0; k < 40 && order.size() < 5; k++)
            cyc(4'hf, dn2(), 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'd0, 4'd0, 1'b0);
        check_order("rot", '{3, 2, 1, 0, 3});

        restart();
        for (int k = 0; k < 30 && order.size() < 3; k++)
            cyc(4'b0101, dn2(), 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'd0, 4'd0, 1'b0);
        check_order("sparse", '{2, 0, 2});

        restart();
        for (int k = 0; k < 30 && order.size() < 2; k++)
            cyc(4'b0010, 4'd0, 1'b0);
        for (int k = 0; k < 2; k++) cyc(4'd0, 4'd0, 1'b0);
        check_order("wd", '{1, 1});
        chk("wd_pulses", to_cnt_a, 1);

        restart();
        cyc(4'b0010, 4'd0, 1'b0);
        cyc(4'b0010, 4'b1001, 1'b0);
        cyc(4'b0010, 4'b1001, 1'b0);
        chk("ign_done", gnt_a, 4'b0010);
        cyc(4'd0, 4'd0, 1'b0);
        chk("drop_gnt", gnt_a, 0);
        cyc(4'd0, 4'd0, 1'b0);
        chk("drop_to", to_cnt_a, 0);

        restart();
        for (int k = 0; k < 10 && !(m0.busy && m0.hold == 4); k++)
            cyc(4'b0100, 4'd0, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        cyc(4'd0, 4'd0, 1'b0);
        chk("coinc_to", to_cnt_a, 0);
        check_order("coinc", '{2});

        restart();
        for (int k = 0; k < 100; k++) cyc(4'b0010, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("nowd_to", to_cnt_b, 0);
        chk("nowd_held", gv_b, 1);
        chk("nowd_idx", idx_b, 1);

        restart();
        cyc(4'hf, 4'd0, 1'b0);
        cyc(4'hf, 4'd0, 1'b0);
        cyc(4'hf, 4'd0, 1'b1);
        chk("mid_rst_gnt", gnt_a, 0);
        chk("mid_rst_valid", gv_a, 0);
        chk("mid_rst_to", to_a, 0);
        cyc(4'b1001, 4'd0, 1'b0);
        chk("post_rst_idx", idx_a, 3);
        chk("post_rst_gnt", gnt_a, 4'b1000);

        for (int k = 0; k < 300; k++) begin
            logic [3:0] r, d;
            r = 4'($urandom);
            d = 4'($urandom) & 4'($urandom);
            cyc(r, d, $urandom_range(0, 49) == 0);
        end

        cyc(4'd0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares a single resource between N requesters.
- Arbitration core reuses the team's priority decoder (highest-order '1' wins), applied to a rotating request mask so priority rotates downward past the last winner.
- Grant is registered and held until the owner signals done or drops its request; a watchdog forces release after MAX_HOLD cycles.
- Sits between requesting pipeline stages and a shared unit, for example a shared memory port or functional unit.

Parameters:
- N, 4, number of requesters; must be >= 2.
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N  request vector; bit i is requester i
- done  in  N  release strobe; only bit gnt_idx is honoured
- gnt  out  N  one-hot grant, registered
- gnt_idx  out  $clog2(N)  binary index of current owner, registered
- gnt_valid  out  1  high while any grant is held (equals |gnt)
- timeout  out  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (synchronous, active-high, sampled on the rising edge of clk):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State=IDLE, last_idx=0, hold_cnt=0.
  - Reset asserted mid-grant drops gnt on the next edge; no timeout pulse is produced.
- States: IDLE, GRANT.
- Selection (combinational, evaluated in IDLE):
  - masked = req & ((1<<last_idx)-1), i.e. only requesters with index below last_idx.
  - If masked != 0, winner = highest set bit of masked; otherwise winner = highest set bit of req.
  - Effect: priority rotates N-1 ... 0 and then wraps back to the top.
  - With last_idx=0 after reset, the highest-index requester wins first.
- IDLE -> GRANT:
  - Any req bit high at edge t: gnt=onehot(winner), gnt_idx=winner and gnt_valid=1 from t+1.
  - last_idx <= winner; hold_cnt <= 1.
  - Latency from request to grant is 1 cycle.
- GRANT, release conditions (evaluated each cycle):
  - (a) done[gnt_idx]=1, or
  - (b) req[gnt_idx]=0, or
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD.
- GRANT with no release condition: hold gnt, hold_cnt <= hold_cnt+1. hold_cnt saturates and cannot wrap.
- GRANT -> IDLE on any release condition:
  - gnt=0, gnt_valid=0 from the next cycle. gnt_idx keeps its last value.
  - The earliest re-grant is 2 cycles after the release edge (one mandatory idle bubble).
- timeout:
  - Pulses high for exactly one cycle, coincident with the first gnt=0 cycle.
  - Fires only when (c) is true and neither (a) nor (b) is true.
  - If done and the watchdog limit coincide, done wins and there is no pulse.
- done bits other than done[gnt_idx] are ignored in all states, as are all done bits in IDLE.
- New requests arriving during GRANT are not latched; they are re-sampled in IDLE.
- gnt is always zero or one-hot. gnt_valid == |gnt at all times.
- Width rules:
  - IDXW = $clog2(N).
  - hold_cnt width = $clog2(MAX_HOLD+1), with a minimum of 1.
  - The mask is computed at N bits; the shift never exceeds N-1.

Decomposition:
- Shared package: IDXW derivation and the state encoding constants (ST_IDLE=0, ST_GRANT=1).
- Sub-module: one instance of prioritydecoder, WIDTH=N, fed by the mux (masked != 0 ? masked : req). Its valid output acts as the any-request flag.
- FSM, watchdog counter and output registers live in rr_arbiter.

Test Plan (N=4, MAX_HOLD=4 unless stated):
- Reset, then req=4'b1111 held, with done[gnt_idx] pulsed 2 cycles after each grant -> grant order 3,2,1,0,3 with one idle cycle between grants.
- req=4'b0101 after reset -> gnt=4'b0100 one cycle later. After done[2], the next gnt is 4'b0001, then 4'b0100 again.
- req=4'b0010 held, done never asserted -> gnt high for 4 cycles, then gnt=0 with timeout=1 for one cycle; re-grant to 1 one cycle later.
- During a grant to 1, pulse done[3] and done[0] -> ignored, grant held. Then drop req[1] -> gnt=0 the next cycle, no timeout.
- During a grant to 2 with hold_cnt=4, assert done[2] in the same cycle -> release with timeout=0. With MAX_HOLD=0, hold for 100 cycles -> no forced release.
- Assert rst mid-grant -> next cycle gnt=0, gnt_valid=0, timeout=0. With req=4'b1001 after reset -> first grant goes to 3.
